// File: rtl/multitap_window_buffer.sv
// Multitap line buffer producing a NUM_TAPS x WINDOW_COLS pixel window with ready/valid flow control.
// Optional MTWB_COORD_EN adds out_x/out_y frame coordinates of the newest sample.
module multitap_window_buffer #(
  parameter int DATA_BITS       = 8,
  parameter int MAX_TAP_SPACING = 1024,
  parameter int NUM_TAPS        = 3,
  parameter int WINDOW_COLS     = 3,
  parameter int COORD_BITS      = 11
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic [COORD_BITS-1:0]                               r_tap_spacing,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [DATA_BITS-1:0]                                in_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [NUM_TAPS-1:0][WINDOW_COLS-1:0][DATA_BITS-1:0] out_data
`ifdef MTWB_COORD_EN
  ,
  output logic [COORD_BITS-1:0]                               out_x,
  output logic [COORD_BITS-1:0]                               out_y
`endif
);

  localparam int WP_W   = (MAX_TAP_SPACING > 1) ? $clog2(MAX_TAP_SPACING) : 1;
  localparam int SP_W   = $clog2(MAX_TAP_SPACING + 1);
  localparam int FILL_W = $clog2(NUM_TAPS * MAX_TAP_SPACING + WINDOW_COLS + 1);

  logic [SP_W-1:0]      spacing;
  logic [WP_W-1:0]      wp;
  logic                 wp_last;
  logic [FILL_W-1:0]    fill_cnt;
  logic [FILL_W-1:0]    fill_target;
  logic                 accept;
  logic                 primed_now;
  logic [DATA_BITS-1:0] row_in [NUM_TAPS];

  function automatic logic [SP_W-1:0] clamp_spacing(input logic [COORD_BITS-1:0] r);
    if (r == '0)
      return SP_W'(1);
    else if (32'(r) > MAX_TAP_SPACING)
      return SP_W'(MAX_TAP_SPACING);
    else
      return SP_W'(r);
  endfunction

  assign in_ready    = reset_n && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign wp_last     = (SP_W'(wp) == spacing - SP_W'(1));
  assign fill_target = FILL_W'((NUM_TAPS - 1) * int'(spacing) + WINDOW_COLS);
  assign primed_now  = (fill_cnt + FILL_W'(1) >= fill_target);

  assign row_in[0] = in_data;

  // Each memory is read before it is overwritten at wp, so it yields the sample S accepts older.
  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_line
    logic [DATA_BITS-1:0] mem [MAX_TAP_SPACING];

    assign row_in[k] = mem[wp];

    always_ff @(posedge clk) begin
      if (accept)
        mem[wp] <= row_in[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spacing   <= clamp_spacing(r_tap_spacing);
      wp        <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      wp <= wp_last ? '0 : wp + WP_W'(1);
      if (fill_cnt != fill_target)
        fill_cnt <= fill_cnt + FILL_W'(1);
      out_valid <= primed_now;
      for (int k = 0; k < NUM_TAPS; k++) begin
        out_data[k][0] <= row_in[k];
        for (int c = 1; c < WINDOW_COLS; c++)
          out_data[k][c] <= out_data[k][c-1];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MTWB_COORD_EN
  // wp already is the column of the sample being accepted; only the row needs its own counter.
  logic [COORD_BITS-1:0] y_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_x  <= '0;
      out_y  <= '0;
      y_next <= '0;
    end else if (accept) begin
      out_x <= COORD_BITS'(wp);
      out_y <= y_next;
      if (wp_last && (y_next != '1))
        y_next <= y_next + COORD_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multitap_window_buffer.sv
// Scoreboard bench for multitap_window_buffer: a sample-history model predicts every window,
// a negedge monitor compares each window as downstream consumes it.
module tb_multitap_window_buffer;

  localparam int NT   = 3;
  localparam int WC   = 3;
  localparam int DB   = 8;
  localparam int CB   = 11;
  localparam int MAXS = 1024;

  typedef logic [NT-1:0][WC-1:0][DB-1:0] win_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CB-1:0] r_tap_spacing;
  logic          in_valid;
  logic          in_ready;
  logic [DB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  win_t          out_data;
`ifdef MTWB_COORD_EN
  logic [CB-1:0] out_x;
  logic [CB-1:0] out_y;
`endif

  int checks = 0;
  int errors = 0;

  multitap_window_buffer #(
    .DATA_BITS(DB), .MAX_TAP_SPACING(MAXS), .NUM_TAPS(NT), .WINDOW_COLS(WC), .COORD_BITS(CB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .r_tap_spacing(r_tap_spacing),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef MTWB_COORD_EN
    ,
    .out_x(out_x),
    .out_y(out_y)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: full history of accepted samples since the last reset.
  byte unsigned hist[$];
  win_t         sb_q[$];
  int           sx_q[$];
  int           sy_q[$];
  int           s_model = 1;
  logic         stalled = 1'b0;
  win_t         held;

  always @(negedge clk) begin
    int   n;
    int   fill;
    win_t w;
    win_t exp_w;
    int   ex;
    int   ey;

    checks++;
    if (in_ready !== (reset_n && (!out_valid || out_ready))) begin
      errors++;
      $display("FAIL in_ready got %b exp %b", in_ready, reset_n && (!out_valid || out_ready));
    end

    if (stalled) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, held);
      end
    end
    stalled = reset_n && out_valid && !out_ready;
    held    = out_data;

    if (out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got window %h with no expected window", out_data);
      end else begin
        exp_w = sb_q.pop_front();
        ex    = sx_q.pop_front();
        ey    = sy_q.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL window got %h exp %h", out_data, exp_w);
        end
`ifdef MTWB_COORD_EN
        checks++;
        if (int'(out_x) != ex || int'(out_y) != ey) begin
          errors++;
          $display("FAIL coord got x=%0d y=%0d exp x=%0d y=%0d", out_x, out_y, ex, ey);
        end
`endif
      end
    end

    if (!reset_n) begin
      hist.delete();
      sb_q.delete();
      sx_q.delete();
      sy_q.delete();
      if (r_tap_spacing == 0)
        s_model = 1;
      else if (int'(r_tap_spacing) > MAXS)
        s_model = MAXS;
      else
        s_model = int'(r_tap_spacing);
    end else if (in_valid && in_ready) begin
      hist.push_back(in_data);
      n    = hist.size() - 1;
      fill = (NT - 1) * s_model + WC;
      if (n >= fill - 1) begin
        for (int k = 0; k < NT; k++)
          for (int c = 0; c < WC; c++)
            w[k][c] = hist[n - k * s_model - c];
        sb_q.push_back(w);
        sx_q.push_back(n % s_model);
        sy_q.push_back((n / s_model > 2047) ? 2047 : n / s_model);
      end
    end
  end

  task automatic do_reset(input int sp);
    @(posedge clk); #1;
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    r_tap_spacing = CB'(sp);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL rst_data got %h exp 0", out_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic stream(input int cycles, input int pv, input int pr);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < pv);
      in_data   = DB'($urandom);
      out_ready = ($urandom_range(99) < pr);
    end
  endtask

  task automatic toggle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      in_valid  = (i % 2 == 0);
      in_data   = DB'($urandom);
      out_ready = 1'b1;
    end
  endtask

  task automatic stall(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = DB'($urandom);
      out_ready = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending windows exp 0", sb_q.size());
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    r_tap_spacing = CB'(6);
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b1;

    do_reset(6);
    stream(60, 100, 100);
    stream(5, 100, 100);
    do_reset(15);
    stream(50, 100, 100);
    stall(5);
    stream(100, 70, 60);
    drain();

    do_reset(0);
    stream(30, 80, 80);
    drain();

    do_reset(MAXS + 7);
    stream(2100, 100, 100);
    toggle(60);
    stream(100, 90, 70);
    drain();

    for (int t = 0; t < 3; t++) begin
      do_reset(int'($urandom_range(40, 1)));
      stream(200, 75, 75);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
